// File: rtl/rv32i_instr_encoder.sv
// rtl/rv32i_instr_encoder.sv - RV32I field-descriptor to instruction-word encoder with 2-entry output FIFO
module rv32i_instr_encoder #(
    parameter int          ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        err_cnt
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    logic [31:0]       instr_q [2];
    logic [ADDR_W-1:0] addr_q  [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              err_q;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [31:0] word;
    logic        legal;
    logic        is_shift;
    logic        fits12, fits13, fits21;
    logic        accept, push, pop;

    // Sign-extension checks: an immediate fits in N signed bits when all bits above N-1 match.
    assign fits12   = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fits13   = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fits21   = (&in_imm[31:20]) | ~(|in_imm[31:20]);
    assign is_shift = (in_opcode == 7'b0010011) &&
                      ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));

    always_comb begin
        word  = 32'd0;
        legal = 1'b0;
        case (in_fmt)
            3'd0: begin
                word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                legal = 1'b1;
            end
            3'd1: begin
                if (is_shift) begin
                    word  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                    legal = ~(|in_imm[31:5]);
                end else begin
                    word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    legal = fits12;
                end
            end
            3'd2: begin
                word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                legal = fits12;
            end
            3'd3: begin
                word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
                legal = fits13 && !in_imm[0];
            end
            3'd4: begin
                word  = {in_imm[31:12], in_rd, in_opcode};
                legal = ~(|in_imm[11:0]);
            end
            3'd5: begin
                word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                legal = fits21 && !in_imm[0];
            end
            default: begin
                word  = 32'd0;
                legal = 1'b0;
            end
        endcase
    end

    // in_ready looks only at registered occupancy so it never combinationally follows out_ready.
    assign in_ready  = !rst && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_instr = instr_q[rd_ptr_q];
    assign out_addr  = addr_q[rd_ptr_q];
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    always_comb begin
        count_d     = count_q;
        next_addr_d = next_addr_q;
        err_cnt_d   = err_cnt_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        if (push) begin
            next_addr_d = next_addr_q + STEP;
        end
        if (accept && !legal && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q[0]  <= 32'd0;
            instr_q[1]  <= 32'd0;
            addr_q[0]   <= BASE;
            addr_q[1]   <= BASE;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            next_addr_q <= BASE;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            if (push) begin
                instr_q[wr_ptr_q] <= word;
                addr_q[wr_ptr_q]  <= next_addr_q;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (accept && !legal) begin
                err_q <= 1'b1;
            end
            count_q     <= count_d;
            next_addr_q <= next_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb/tb_rv32i_instr_encoder.sv - scoreboard bench for rv32i_instr_encoder
module tb_rv32i_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [11:0] out_addr;
    logic        err;
    logic [7:0]  err_cnt;

    rv32i_instr_encoder #(.ADDR_W(12), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [11:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_addr = 12'h000;
    int          exp_err_cnt = 0;
    bit          exp_err = 1'b0;
    bit          stim_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] bits(input int imm, input int hi, input int lo);
        logic [31:0] u;
        u = imm;
        return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    function automatic bit ref_shift(input int fmt, input int op, input int f3);
        return fmt == 1 && op == 'h13 && (f3 == 1 || f3 == 5);
    endfunction

    function automatic bit ref_legal(input int fmt, input int op, input int f3, input int imm);
        case (fmt)
            0: return 1'b1;
            1: return ref_shift(fmt, op, f3) ? (imm >= 0 && imm < 32) : (imm >= -2048 && imm <= 2047);
            2: return imm >= -2048 && imm <= 2047;
            3: return imm >= -4096 && imm <= 4094 && (imm & 1) == 0;
            4: return (imm & 'hFFF) == 0;
            5: return imm >= -1048576 && imm <= 1048574 && (imm & 1) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_encode(input int fmt, input int op, input int rd, input int rs1,
                                               input int rs2, input int f3, input int f7, input int imm);
        logic [31:0] base;
        base = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
        case (fmt)
            0: return base | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25);
            1: if (ref_shift(fmt, op, f3))
                   return base | (32'(rd) << 7) | (bits(imm, 4, 0) << 20) | (32'(f7) << 25);
               else
                   return base | (32'(rd) << 7) | (bits(imm, 11, 0) << 20);
            2: return base | (bits(imm, 4, 0) << 7) | (32'(rs2) << 20) | (bits(imm, 11, 5) << 25);
            3: return base | (bits(imm, 11, 11) << 7) | (bits(imm, 4, 1) << 8) | (32'(rs2) << 20)
                      | (bits(imm, 10, 5) << 25) | (bits(imm, 12, 12) << 31);
            4: return 32'(op) | (32'(rd) << 7) | (bits(imm, 31, 12) << 12);
            5: return 32'(op) | (32'(rd) << 7) | (bits(imm, 19, 12) << 12) | (bits(imm, 11, 11) << 20)
                      | (bits(imm, 10, 1) << 21) | (bits(imm, 20, 20) << 31);
            default: return 32'd0;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input int fmt, input int op, input int rd, input int rs1, input int rs2,
                        input int f3, input int f7, input int imm,
                        input bit use_k, input logic [31:0] k);
        exp_t e;
        int   waited;
        in_fmt = 3'(fmt); in_opcode = 7'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1);
        in_rs2 = 5'(rs2); in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = imm;
        in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready) begin
            waited++;
            if (waited > 64) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 64 cycles");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (ref_legal(fmt, op, f3, imm)) begin
            e.instr = use_k ? k : ref_encode(fmt, op, rd, rs1, rs2, f3, f7, imm);
            e.addr  = exp_addr;
            sb.push_back(e);
            exp_addr = exp_addr + 12'd4;
        end else begin
            exp_err = 1'b1;
            if (exp_err_cnt < 255) exp_err_cnt++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        sb.delete();
        exp_addr = 12'h000; exp_err = 1'b0; exp_err_cnt = 0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_word: got %08h@%03h expected none", out_instr, out_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_instr", out_instr, e.instr);
                check("out_addr", 32'(out_addr), 32'(e.addr));
            end
        end
    end

    int bfmt [15] = '{1, 1, 1, 2, 3, 3, 3, 5, 5, 5, 1, 1, 4, 6, 7};
    int bop  [15] = '{'h13, 'h13, 'h13, 'h23, 'h63, 'h63, 'h63, 'h6F, 'h6F, 'h6F, 'h13, 'h13, 'h37, 'h13, 'h33};
    int bf3  [15] = '{0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0};
    int bimm [15] = '{2047, -2048, -2049, 2048, 4094, -4096, 4096, 1048574, -1048576, 1048576, 31, 32, 1, 0, 0};

    initial begin
        @(posedge clk); #1;
        do_reset();
        out_ready = 1'b1;

        send(1, 'h13, 1, 0, 0, 0, 0, 5, 1'b1, 32'h00500093);
        send(0, 'h33, 3, 1, 2, 0, 'h20, 0, 1'b1, 32'h402081B3);
        send(2, 'h23, 0, 2, 5, 2, 0, 8, 1'b1, 32'h00512423);
        send(3, 'h63, 0, 1, 2, 0, 0, -4, 1'b1, 32'hFE208EE3);
        send(4, 'h37, 5, 0, 0, 0, 0, 'h12345000, 1'b1, 32'h123452B7);
        send(5, 'h6F, 1, 0, 0, 0, 0, 2048, 1'b1, 32'h001000EF);

        send(1, 'h13, 1, 0, 0, 0, 0, 2048, 1'b0, 32'd0);
        send(3, 'h63, 0, 1, 2, 0, 0, 3, 1'b0, 32'd0);
        check("err_after_illegal", 32'(err), 32'(exp_err));
        check("err_cnt_after_illegal", 32'(err_cnt), 32'(exp_err_cnt));
        send(0, 'h33, 7, 8, 9, 0, 0, 0, 1'b0, 32'd0);

        for (int i = 0; i < 15; i++)
            send(bfmt[i], bop[i], 3, 4, 5, bf3[i], 'h20, bimm[i], 1'b0, 32'd0);
        repeat (4) @(posedge clk);
        #1;

        do_reset();
        out_ready = 1'b0;
        send(1, 'h13, 1, 0, 0, 0, 0, 5, 1'b0, 32'd0);
        send(1, 'h13, 2, 0, 0, 0, 0, 6, 1'b0, 32'd0);
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("stall_head_instr", out_instr, sb[0].instr);
        check("stall_head_addr", 32'(out_addr), 32'(sb[0].addr));
        @(posedge clk); #1;
        fork
            send(1, 'h13, 3, 0, 0, 0, 0, 7, 1'b0, 32'd0);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(0, 'h33, 1, 2, 3, 0, 0, 0, 1'b0, 32'd0);
        send(0, 'h33, 4, 5, 6, 0, 0, 0, 1'b0, 32'd0);
        do_reset();
        out_ready = 1'b1;
        send(4, 'h37, 9, 0, 0, 0, 0, 'h0ABCD000, 1'b0, 32'd0);

        fork
            begin
                for (int i = 0; i < 1400; i++) begin
                    int fmt, op, f3, imm, sel;
                    sel = $urandom_range(0, 19);
                    fmt = (sel >= 18) ? sel - 12 : sel % 6;
                    op  = $urandom_range(0, 127);
                    f3  = $urandom_range(0, 7);
                    if (fmt == 1 && $urandom_range(0, 1) == 1) op = 'h13;
                    case (fmt)
                        1: imm = ref_shift(fmt, op, f3) ? int'($urandom_range(0, 31))
                                                        : int'($urandom_range(0, 4095)) - 2048;
                        2: imm = int'($urandom_range(0, 4095)) - 2048;
                        3: imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
                        4: imm = int'($urandom & 32'hFFFFF000);
                        5: imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                        default: imm = int'($urandom);
                    endcase
                    if ($urandom_range(0, 99) < 15) imm = int'($urandom);
                    send(fmt, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                         f3, $urandom_range(0, 127), imm, 1'b0, 32'd0);
                end
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join

        out_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("final_out_valid", 32'(out_valid), 32'd0);
        check("final_err", 32'(err), 32'(exp_err));
        check("final_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
- Inverse of the RV32I instruction decoder: takes field-level descriptors and emits packed 32-bit RV32I instruction words.
- Descriptors arrive on a valid/ready stream. Encoded words are buffered in a 2-entry output FIFO.
- Each word is tagged with a sequential instruction-memory address, so the block can load program memory and generate stimulus for the decode stage.

Parameters:
- ADDR_W, 12, width of instruction-memory byte address.
- BASE_ADDR, 0, address attached to the first word emitted after reset.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal
- in_opcode  in  7  opcode, passed through to bits [6:0]
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7; used for R-type and for I-type shifts
- in_imm  in  32  signed immediate as a byte value; U-type takes the full value
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address of out_instr
- err  out  1  sticky illegal-descriptor flag
- err_cnt  out  8  count of dropped descriptors, saturates at 255

Behaviour:
- Reset (async, rst=1): FIFO empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, err_cnt=0, in_ready=0 while rst is high. Reset mid-stream discards both FIFO entries.
- in_ready = !rst && FIFO not full. It depends on registered state only, not on out_ready.
- Encoding is combinational. The result is pushed on the accept edge, so the earliest out_valid is the cycle after accept (latency 1).
- Field placement: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25], per format:
  - R: all fields above.
  - I: imm[11:0] to [31:20].
  - I-type shift (opcode 0010011, funct3 001 or 101): bits [31:25]=funct7, bits [24:20]=imm[4:0].
  - S: imm[11:5] to [31:25], imm[4:0] to [11:7].
  - B: imm[12] to [31], imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to [7].
  - U: imm[31:12] to [31:12].
  - J: imm[20] to [31], imm[10:1] to [30:21], imm[11] to [20], imm[19:12] to [19:12].
- Fields that a format does not use are ignored and contribute 0.
- Illegal descriptor conditions:
  - fmt is 6 or 7.
  - I or S imm outside [-2048, 2047].
  - Shift imm[31:5] != 0.
  - B imm outside [-4096, 4094] or imm[0]=1.
  - J imm outside [-1048576, 1048574] or imm[0]=1.
  - U imm[11:0] != 0.
- Illegal descriptors are still accepted (handshake completes), never pushed. They set err and increment err_cnt (saturating at 255). No address is consumed.
- FIFO behaviour:
  - 2 entries.
  - Simultaneous push and pop when full is not possible, because in_ready is low when full.
  - Simultaneous push and pop when holding 1 entry keeps the occupancy at 1.
  - Output data holds stable while out_valid && !out_ready.
- Address counter:
  - Assigned at push time; advances by 4 per pushed word.
  - Wraps modulo 2^ADDR_W (e.g. 0xFFC, then 0x000 for ADDR_W=12).
  - out_addr shows the address of the FIFO head; it shows BASE_ADDR when the FIFO is empty after reset.

Test Plan:
- ADDI x1,x0,5 (fmt=1, opcode=0x13, rd=1, rs1=0, f3=0, imm=5), out_ready=1 -> out_instr=0x00500093, out_addr=0x000, one cycle after accept.
- SUB x3,x1,x2 (fmt=0, 0x33, f7=0x20), then SW x5,8(x2) (fmt=2, 0x23, f3=2, imm=8) -> 0x402081B3 @0x000, then 0x00512423 @0x004.
- BEQ x1,x2,-4 (fmt=3, 0x63, imm=-4) -> 0xFE208EE3; LUI x5 (fmt=4, 0x37, imm=0x12345000) -> 0x123452B7; JAL x1,2048 (fmt=5, 0x6F) -> 0x001000EF.
- ADDI with imm=2048, then BEQ with imm=3 -> nothing emitted, err=1, err_cnt=2. The next legal word still gets the next sequential address.
- out_ready=0 with 3 back-to-back descriptors -> in_ready drops after 2 accepts. On release: words pop in order at addresses 0x000, 0x004, 0x008; no loss or duplication.
- Assert rst with 2 words queued -> out_valid=0 immediately; after release the first word is at BASE_ADDR and err_cnt=0.
